// File: rtl/mem_bus_sched.sv
// Memory bus scheduler: arbitrates one single-port RAM between instruction fetch
// and load/store, with a starvation guard that lets a pending fetch through.
module mem_bus_sched #(
   parameter int unsigned RAM_LAT    = 1,
   parameter int unsigned MAX_LS_RUN = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [7:0]  if_pc,
   output logic        if_ack,
   output logic [31:0] if_instr,
   input  logic        ls_req,
   input  logic [3:0]  ls_opcode,
   input  logic [15:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ack,
   output logic        ls_err,
   output logic [31:0] ls_rdata,
   output logic        ram_en,
   output logic        ram_rw,
   output logic [15:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ACC_IF  = 3'd1;
   localparam logic [2:0] ACC_LD  = 3'd2;
   localparam logic [2:0] ACC_ST  = 3'd3;
   localparam logic [2:0] WAIT_RD = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam logic [3:0] OP_LDR = 4'b1001;
   localparam logic [3:0] OP_STR = 4'b1010;

   localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);
   localparam logic [1:0] RUN_MAX  = 2'(MAX_LS_RUN);

   logic [2:0] state;
   logic [1:0] starve_cnt;
   logic [1:0] lat_cnt;
   logic       own_if;
   logic       err_pend;
   logic       fetch_win;

   // Fetch only beats a pending load/store once the load/store run is exhausted.
   assign fetch_win = if_req && (!ls_req || (starve_cnt == RUN_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         lat_cnt    <= '0;
         own_if     <= 1'b0;
         err_pend   <= 1'b0;
         if_ack     <= 1'b0;
         if_instr   <= '0;
         ls_ack     <= 1'b0;
         ls_err     <= 1'b0;
         ls_rdata   <= '0;
         ram_en     <= 1'b0;
         ram_rw     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         if_ack <= 1'b0;
         ls_ack <= 1'b0;
         ls_err <= 1'b0;
         ram_en <= 1'b0;
         ram_rw <= 1'b0;
         case (state)
            IDLE: begin
               if (fetch_win) begin
                  state      <= ACC_IF;
                  own_if     <= 1'b1;
                  err_pend   <= 1'b0;
                  starve_cnt <= '0;
                  ram_en     <= 1'b1;
                  ram_addr   <= {8'h00, if_pc};
               end else if (ls_req) begin
                  own_if     <= 1'b0;
                  starve_cnt <= if_req ? starve_cnt + 2'd1 : 2'd0;
                  case (ls_opcode)
                     OP_LDR: begin
                        state    <= ACC_LD;
                        err_pend <= 1'b0;
                        ram_en   <= 1'b1;
                        ram_addr <= ls_addr;
                     end
                     OP_STR: begin
                        state     <= ACC_ST;
                        err_pend  <= 1'b0;
                        ram_en    <= 1'b1;
                        ram_rw    <= 1'b1;
                        ram_addr  <= ls_addr;
                        ram_wdata <= ls_wdata;
                     end
                     default: begin
                        state    <= DONE;
                        err_pend <= 1'b1;
                     end
                  endcase
               end
            end
            ACC_IF, ACC_LD: begin
               state   <= WAIT_RD;
               lat_cnt <= LAT_LAST;
            end
            ACC_ST: state <= DONE;
            WAIT_RD: begin
               if (lat_cnt == 2'd0) begin
                  if (own_if) if_instr <= ram_rdata;
                  else        ls_rdata <= ram_rdata;
                  state <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            DONE: begin
               // The ack flop is set on leaving DONE, so it is seen in the first IDLE cycle.
               state <= IDLE;
               if (own_if) begin
                  if_ack <= 1'b1;
               end else begin
                  ls_ack <= 1'b1;
                  ls_err <= err_pend;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_sched.sv
// Directed bench for mem_bus_sched: one instance at RAM_LAT=1, one at RAM_LAT=3,
// each with a simple behavioural RAM returning a fixed word per address.
module tb_mem_bus_sched;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        if_req, ls_req, ls_req3, if_req3;
   logic [7:0]  if_pc;
   logic [3:0]  ls_opcode;
   logic [15:0] ls_addr;
   logic [31:0] ls_wdata;

   logic        if_ack, ls_ack, ls_err, ram_en, ram_rw;
   logic [31:0] if_instr, ls_rdata, ram_wdata, ram_rdata;
   logic [15:0] ram_addr;

   logic        if_ack_3, ls_ack_3, ls_err_3, ram_en_3, ram_rw_3;
   logic [31:0] if_instr_3, ls_rdata_3, ram_wdata_3, ram_rdata_3;
   logic [15:0] ram_addr_3;

   int n_checks = 0;
   int n_fails  = 0;

   mem_bus_sched #(.RAM_LAT(1), .MAX_LS_RUN(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_pc(if_pc), .if_ack(if_ack), .if_instr(if_instr),
      .ls_req(ls_req), .ls_opcode(ls_opcode), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_err(ls_err), .ls_rdata(ls_rdata),
      .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   mem_bus_sched #(.RAM_LAT(3), .MAX_LS_RUN(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req3), .if_pc(if_pc), .if_ack(if_ack_3), .if_instr(if_instr_3),
      .ls_req(ls_req3), .ls_opcode(ls_opcode), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack_3), .ls_err(ls_err_3), .ls_rdata(ls_rdata_3),
      .ram_en(ram_en_3), .ram_rw(ram_rw_3), .ram_addr(ram_addr_3), .ram_wdata(ram_wdata_3),
      .ram_rdata(ram_rdata_3)
   );

   function automatic logic [31:0] ram_word(input logic [15:0] a);
      case (a)
         16'h0005: ram_word = 32'hE3A00001;
         16'h0011: ram_word = 32'h00000018;
         default:  ram_word = {16'hA5A5, a};
      endcase
   endfunction

   // Read data is only valid exactly RAM_LAT cycles after a read strobe.
   always @(posedge clk)
      ram_rdata <= (ram_en && !ram_rw) ? ram_word(ram_addr) : 32'hDEADBEEF;

   logic [31:0] d1, d2;
   logic        v1, v2;
   always @(posedge clk) begin
      v1 <= ram_en_3 && !ram_rw_3;
      d1 <= ram_word(ram_addr_3);
      v2 <= v1;
      d2 <= d1;
      ram_rdata_3 <= v2 ? d2 : 32'hDEADBEEF;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic        snap_en, snap_rw, ack_err;
   logic [15:0] snap_addr;
   logic [31:0] snap_wdata;

   // sel: 0 = fetch on u_dut, 1 = load/store on u_dut, 2 = load/store on u_dut3.
   // cyc = number of rising edges after the grant edge until the ack is visible.
   task automatic run_req(input int sel, input bit drop_early, output int cyc, output int en_cnt);
      bit got;
      got = 1'b0;
      cyc = -1;
      en_cnt = 0;
      while (!got && cyc < 30) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (drop_early) begin
            if_req = 1'b0; ls_req = 1'b0; ls_req3 = 1'b0;
         end
         if (cyc == 0) begin
            snap_en    = (sel == 2) ? ram_en_3    : ram_en;
            snap_rw    = (sel == 2) ? ram_rw_3    : ram_rw;
            snap_addr  = (sel == 2) ? ram_addr_3  : ram_addr;
            snap_wdata = (sel == 2) ? ram_wdata_3 : ram_wdata;
         end
         en_cnt += (sel == 2) ? int'(ram_en_3) : int'(ram_en);
         case (sel)
            0:       got = if_ack;
            1:       got = ls_ack;
            default: got = ls_ack_3;
         endcase
         if (got && sel != 2) check("ack_exclusive", {if_ack, ls_ack}, {sel == 0, sel == 1});
      end
      ack_err = (sel == 2) ? ls_err_3 : ls_err;
      if_req = 1'b0; ls_req = 1'b0; ls_req3 = 1'b0;
      check("ack_seen", got, 1);
   endtask

   int          cyc, en_cnt, n_acks;
   logic [5:0]  seq;

   initial begin
      rst_n = 1'b0;
      if_req = 1'b0; ls_req = 1'b0; ls_req3 = 1'b0; if_req3 = 1'b0;
      if_pc = '0; ls_opcode = '0; ls_addr = '0; ls_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl",  {if_ack, ls_ack, ls_err, ram_en, ram_rw}, 0);
      check("reset_data",  {ram_addr, ram_wdata, if_instr} | {16'h0, ls_rdata, 32'h0}, 0);
      check("reset_ctrl3", {if_ack_3, ls_ack_3, ls_err_3, ram_en_3, ram_rw_3}, 0);
      rst_n = 1'b1;

      // Fetch alone, latency 1
      if_pc = 8'h05; if_req = 1'b1;
      run_req(0, 1'b0, cyc, en_cnt);
      check("fetch_latency", cyc, 3);
      check("fetch_ram_en",  snap_en, 1);
      check("fetch_ram_rw",  snap_rw, 0);
      check("fetch_addr",    snap_addr, 16'h0005);
      check("fetch_instr",   if_instr, 32'hE3A00001);
      check("fetch_en_cnt",  en_cnt, 1);
      @(posedge clk); @(negedge clk);
      check("fetch_ack_pulse", if_ack, 0);

      // Store
      ls_opcode = 4'b1010; ls_addr = 16'h0021; ls_wdata = 32'h3; ls_req = 1'b1;
      run_req(1, 1'b0, cyc, en_cnt);
      check("store_latency", cyc, 2);
      check("store_ram_en",  snap_en, 1);
      check("store_ram_rw",  snap_rw, 1);
      check("store_addr",    snap_addr, 16'h0021);
      check("store_wdata",   snap_wdata, 32'h3);
      check("store_en_cnt",  en_cnt, 1);
      check("store_err",     ack_err, 0);
      @(posedge clk); @(negedge clk);
      check("idle_strobes",  {ram_en, ram_rw, ls_ack}, 0);
      check("idle_addr_hold",  ram_addr, 16'h0021);
      check("idle_wdata_hold", ram_wdata, 32'h3);

      // Load with latency 3
      ls_opcode = 4'b1001; ls_addr = 16'h0011; ls_req3 = 1'b1;
      run_req(2, 1'b0, cyc, en_cnt);
      check("load3_latency", cyc, 5);
      check("load3_addr",    snap_addr, 16'h0011);
      check("load3_rw",      snap_rw, 0);
      check("load3_rdata",   ls_rdata_3, 32'h18);

      // Load on the latency-1 instance with the request dropped after the grant
      ls_req = 1'b1;
      run_req(1, 1'b1, cyc, en_cnt);
      check("drop_latency", cyc, 3);
      check("drop_rdata",   ls_rdata, 32'h18);

      // Illegal opcode
      ls_opcode = 4'b0110; ls_addr = 16'h0044; ls_req = 1'b1;
      run_req(1, 1'b0, cyc, en_cnt);
      check("illegal_latency", cyc, 1);
      check("illegal_no_ram",  en_cnt, 0);
      check("illegal_err",     ack_err, 1);
      check("illegal_rdata_kept", ls_rdata, 32'h18);

      // Contention: both requests held high
      ls_opcode = 4'b1010; ls_addr = 16'h0030; ls_wdata = 32'h7; if_pc = 8'h05;
      if_req = 1'b1; ls_req = 1'b1;
      seq = '0; n_acks = 0; cyc = 0;
      while (n_acks < 6 && cyc < 200) begin
         @(posedge clk); @(negedge clk);
         cyc++;
         if (if_ack || ls_ack) begin
            check("contend_exclusive", if_ack & ls_ack, 0);
            seq = {seq[4:0], if_ack};
            n_acks++;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      check("contend_order", seq, 6'b001001);

      // Reset during WAIT_RD on the latency-3 instance
      repeat (2) @(negedge clk);
      ls_opcode = 4'b1001; ls_addr = 16'h0011; ls_req3 = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      #2 rst_n = 1'b0; ls_req3 = 1'b0;
      #1;
      check("rst_mid_ctrl",  {if_ack_3, ls_ack_3, ls_err_3, ram_en_3, ram_rw_3}, 0);
      check("rst_mid_addr",  ram_addr_3, 0);
      check("rst_mid_rdata", ls_rdata_3, 0);
      check("rst_mid_instr", if_instr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n_acks = 0;
      repeat (10) begin
         @(posedge clk); @(negedge clk);
         n_acks += int'(ls_ack_3) + int'(ls_ack) + int'(if_ack);
      end
      check("rst_no_ack", n_acks, 0);

      // First arbitration after release
      if_pc = 8'h05; if_req = 1'b1;
      run_req(0, 1'b0, cyc, en_cnt);
      check("post_rst_latency", cyc, 3);
      check("post_rst_instr",   if_instr, 32'hE3A00001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
